// File: rtl/vmu_mem_arbiter.sv
// Round-robin memory-request arbiter for the VMU engines, with per-channel load credits
// and routing of load responses back to their channel through the ticket's channel id.
module vmu_mem_arbiter #(
  parameter int  NUM_CH         = 4,
  parameter int  ADDR_WIDTH     = 32,
  parameter int  REQ_DATA_WIDTH = 256,
  parameter int  TICKET_WIDTH   = 4,
  parameter int  MAX_OUTST      = 8,
  localparam int CH_W           = $clog2(NUM_CH),
  localparam int CNT_W          = $clog2(MAX_OUTST + 1),
  localparam int MT_W           = CH_W + TICKET_WIDTH
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [NUM_CH-1:0]                ch_req_valid_i,
  input  logic [NUM_CH-1:0]                ch_req_store_i,
  input  logic [NUM_CH*ADDR_WIDTH-1:0]     ch_req_addr_i,
  input  logic [NUM_CH*REQ_DATA_WIDTH-1:0] ch_req_data_i,
  input  logic [NUM_CH*TICKET_WIDTH-1:0]   ch_req_ticket_i,
  output logic [NUM_CH-1:0]                ch_grant_o,
  output logic                             mem_req_valid_o,
  output logic                             mem_req_store_o,
  output logic [ADDR_WIDTH-1:0]            mem_req_addr_o,
  output logic [REQ_DATA_WIDTH-1:0]        mem_req_data_o,
  output logic [MT_W-1:0]                  mem_req_ticket_o,
  input  logic                             cache_ready_i,
  input  logic                             mem_resp_valid_i,
  input  logic [MT_W-1:0]                  mem_resp_ticket_i,
  input  logic [REQ_DATA_WIDTH-1:0]        mem_resp_data_i,
  output logic [NUM_CH-1:0]                ch_resp_valid_o,
  output logic [TICKET_WIDTH-1:0]          ch_resp_ticket_o,
  output logic [REQ_DATA_WIDTH-1:0]        ch_resp_data_o,
  output logic                             resp_err_o,
  output logic                             idle_o
);

  logic [CH_W-1:0]           rr_ptr;
  logic [CNT_W-1:0]          cnt [NUM_CH];
  logic                      stage_free;
  logic [NUM_CH-1:0]         eligible;
  logic                      grant_any;
  logic [CH_W-1:0]           grant_idx;
  logic [CH_W:0]             scan_idx;
  logic                      sel_store;
  logic [ADDR_WIDTH-1:0]     sel_addr;
  logic [REQ_DATA_WIDTH-1:0] sel_data;
  logic [TICKET_WIDTH-1:0]   sel_ticket;
  logic [CH_W-1:0]           resp_ch;
  logic                      resp_ok;
  logic [NUM_CH-1:0]         cnt_inc;
  logic [NUM_CH-1:0]         cnt_dec;
  logic                      cnt_zero_all;

  // The stage may drain and refill in the same cycle.
  assign stage_free = ~mem_req_valid_o | cache_ready_i;
  assign resp_ch    = mem_resp_ticket_i[MT_W-1:TICKET_WIDTH];

  always_comb begin
    eligible = '0;
    for (int k = 0; k < NUM_CH; k++)
      eligible[k] = ch_req_valid_i[k] &
                    (ch_req_store_i[k] | (cnt[k] < CNT_W'(MAX_OUTST)));
  end

  always_comb begin
    grant_any  = 1'b0;
    grant_idx  = '0;
    scan_idx   = '0;
    ch_grant_o = '0;
    if (stage_free) begin
      for (int i = 0; i < NUM_CH; i++) begin
        scan_idx = {1'b0, rr_ptr} + (CH_W+1)'(i);
        if (scan_idx >= (CH_W+1)'(NUM_CH))
          scan_idx = scan_idx - (CH_W+1)'(NUM_CH);
        if (!grant_any && eligible[scan_idx[CH_W-1:0]]) begin
          grant_any = 1'b1;
          grant_idx = scan_idx[CH_W-1:0];
        end
      end
    end
    if (grant_any)
      ch_grant_o[grant_idx] = 1'b1;
  end

  always_comb begin
    sel_store  = 1'b0;
    sel_addr   = '0;
    sel_data   = '0;
    sel_ticket = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      if (grant_idx == CH_W'(k)) begin
        sel_store  = ch_req_store_i[k];
        sel_addr   = ch_req_addr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
        sel_data   = ch_req_data_i[k*REQ_DATA_WIDTH +: REQ_DATA_WIDTH];
        sel_ticket = ch_req_ticket_i[k*TICKET_WIDTH +: TICKET_WIDTH];
      end
    end
  end

  // A response is only routable when its channel actually has a load in flight.
  always_comb begin
    cnt_inc = ch_grant_o & ~ch_req_store_i;
    cnt_dec = '0;
    for (int k = 0; k < NUM_CH; k++)
      if (mem_resp_valid_i && (resp_ch == CH_W'(k)) && (cnt[k] != '0))
        cnt_dec[k] = 1'b1;
  end

  assign resp_ok = |cnt_dec;

  always_comb begin
    cnt_zero_all = 1'b1;
    for (int k = 0; k < NUM_CH; k++)
      if (cnt[k] != '0)
        cnt_zero_all = 1'b0;
  end

  assign idle_o = ~mem_req_valid_o & cnt_zero_all;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr           <= '0;
      mem_req_valid_o  <= 1'b0;
      mem_req_store_o  <= 1'b0;
      mem_req_addr_o   <= '0;
      mem_req_data_o   <= '0;
      mem_req_ticket_o <= '0;
    end else if (grant_any) begin
      mem_req_valid_o  <= 1'b1;
      mem_req_store_o  <= sel_store;
      mem_req_addr_o   <= sel_addr;
      mem_req_data_o   <= sel_data;
      mem_req_ticket_o <= {grant_idx, sel_ticket};
      rr_ptr           <= (grant_idx == CH_W'(NUM_CH-1)) ? '0 : grant_idx + CH_W'(1);
    end else if (cache_ready_i) begin
      mem_req_valid_o  <= 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int k = 0; k < NUM_CH; k++)
        cnt[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_CH; k++) begin
        if (cnt_inc[k] && !cnt_dec[k])
          cnt[k] <= cnt[k] + CNT_W'(1);
        else if (!cnt_inc[k] && cnt_dec[k])
          cnt[k] <= cnt[k] - CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ch_resp_valid_o  <= '0;
      ch_resp_ticket_o <= '0;
      ch_resp_data_o   <= '0;
      resp_err_o       <= 1'b0;
    end else begin
      ch_resp_valid_o <= cnt_dec;
      resp_err_o      <= mem_resp_valid_i & ~resp_ok;
      if (resp_ok) begin
        ch_resp_ticket_o <= mem_resp_ticket_i[TICKET_WIDTH-1:0];
        ch_resp_data_o   <= mem_resp_data_i;
      end
    end
  end

endmodule

// File: tb/tb_vmu_mem_arbiter.sv
// Scoreboard bench for vmu_mem_arbiter: stimulus queues expected cache requests and
// channel responses, a monitor pops and compares them as the DUT presents them.
module tb_vmu_mem_arbiter;
  localparam int NCH = 4, AW = 32, DW = 32, TW = 4, MO = 2, CW = 2, MTW = 6;

  typedef struct packed {
    logic           store;
    logic [AW-1:0]  addr;
    logic [DW-1:0]  data;
    logic [MTW-1:0] tkt;
  } req_t;

  typedef struct packed {
    logic           err;
    logic [NCH-1:0] v;
    logic [TW-1:0]  tkt;
    logic [DW-1:0]  data;
  } rsp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NCH-1:0] v, st;
  logic [AW-1:0]  a [NCH];
  logic [DW-1:0]  d [NCH];
  logic [TW-1:0]  t [NCH];
  logic           ready, rv;
  logic [MTW-1:0] rt;
  logic [DW-1:0]  rd;

  logic [NCH*AW-1:0] addr_p;
  logic [NCH*DW-1:0] data_p;
  logic [NCH*TW-1:0] tkt_p;
  assign addr_p = {a[3], a[2], a[1], a[0]};
  assign data_p = {d[3], d[2], d[1], d[0]};
  assign tkt_p  = {t[3], t[2], t[1], t[0]};

  logic [NCH-1:0] ch_grant_o, ch_resp_valid_o;
  logic           mem_req_valid_o, mem_req_store_o, resp_err_o, idle_o;
  logic [AW-1:0]  mem_req_addr_o;
  logic [DW-1:0]  mem_req_data_o, ch_resp_data_o;
  logic [MTW-1:0] mem_req_ticket_o;
  logic [TW-1:0]  ch_resp_ticket_o;

  vmu_mem_arbiter #(
    .NUM_CH(NCH), .ADDR_WIDTH(AW), .REQ_DATA_WIDTH(DW), .TICKET_WIDTH(TW), .MAX_OUTST(MO)
  ) dut (
    .clk(clk), .rst(rst),
    .ch_req_valid_i(v), .ch_req_store_i(st), .ch_req_addr_i(addr_p),
    .ch_req_data_i(data_p), .ch_req_ticket_i(tkt_p),
    .ch_grant_o(ch_grant_o),
    .mem_req_valid_o(mem_req_valid_o), .mem_req_store_o(mem_req_store_o),
    .mem_req_addr_o(mem_req_addr_o), .mem_req_data_o(mem_req_data_o),
    .mem_req_ticket_o(mem_req_ticket_o),
    .cache_ready_i(ready),
    .mem_resp_valid_i(rv), .mem_resp_ticket_i(rt), .mem_resp_data_i(rd),
    .ch_resp_valid_o(ch_resp_valid_o), .ch_resp_ticket_o(ch_resp_ticket_o),
    .ch_resp_data_o(ch_resp_data_o), .resp_err_o(resp_err_o), .idle_o(idle_o)
  );

  int   checks = 0, failures = 0;
  req_t req_q[$];
  rsp_t rsp_q[$];

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    end
  endtask

  task automatic push_req(input int k);
    req_t r;
    r.store = st[k];
    r.addr  = a[k];
    r.data  = d[k];
    r.tkt   = {CW'(k), t[k]};
    req_q.push_back(r);
  endtask

  task automatic push_rsp(input logic err, input logic [NCH-1:0] vv,
                          input logic [TW-1:0] tk, input logic [DW-1:0] dd);
    rsp_t r;
    r.err  = err;
    r.v    = vv;
    r.tkt  = tk;
    r.data = dd;
    rsp_q.push_back(r);
  endtask

  task automatic send_rsp(input int ch, input logic [TW-1:0] tk, input logic [DW-1:0] dd);
    rv = 1'b1;
    rt = {CW'(ch), tk};
    rd = dd;
  endtask

  // Inputs are set just after a rising edge; grant is checked on the falling edge.
  task automatic step(input logic [NCH-1:0] exp_g, input string nm);
    @(negedge clk);
    chk(nm, ch_grant_o, exp_g);
    @(posedge clk);
    #1;
  endtask

  initial begin : monitor
    req_t er;
    rsp_t es;
    forever begin
      @(negedge clk);
      if (mem_req_valid_o && ready) begin
        if (req_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL req_unexpected got_ticket=%0h exp=no_request", mem_req_ticket_o);
        end else begin
          er = req_q.pop_front();
          chk("req_store", mem_req_store_o, er.store);
          chk("req_addr", mem_req_addr_o, er.addr);
          chk("req_data", mem_req_data_o, er.data);
          chk("req_ticket", mem_req_ticket_o, er.tkt);
        end
      end
      if ((ch_resp_valid_o != '0) || resp_err_o) begin
        if (rsp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL rsp_unexpected got_valid=%0h got_err=%0b exp=no_response",
                   ch_resp_valid_o, resp_err_o);
        end else begin
          es = rsp_q.pop_front();
          chk("rsp_err", resp_err_o, es.err);
          chk("rsp_valid", ch_resp_valid_o, es.v);
          if (!es.err) begin
            chk("rsp_ticket", ch_resp_ticket_o, es.tkt);
            chk("rsp_data", ch_resp_data_o, es.data);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "timeout");
  end

  initial begin
    v = '0; st = '0; ready = 1'b0; rv = 1'b0; rt = '0; rd = '0;
    for (int k = 0; k < NCH; k++) begin
      a[k] = 32'h1000 + 32'(16 * k);
      d[k] = 32'hD000_0000 + 32'(k);
      t[k] = TW'(k + 4);
    end

    // Reset values
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst0_req_valid", mem_req_valid_o, 0);
    chk("rst0_resp_valid", ch_resp_valid_o, 0);
    chk("rst0_err", resp_err_o, 0);
    chk("rst0_idle", idle_o, 1);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Round robin: all channels hold a load
    ready = 1'b1;
    v = 4'hF;
    for (int i = 0; i < 5; i++) begin
      push_req(i % 4);
      step(NCH'(1 << (i % 4)), "rr_grant");
    end
    v = '0;
    step('0, "rr_no_req");
    chk("rr_idle_busy", idle_o, 0);

    // Reset mid-traffic with a request stuck under back-pressure
    ready = 1'b0;
    v = 4'b0100;
    step(4'b0100, "pre_rst_grant");
    v = '0;
    chk("stuck_valid", mem_req_valid_o, 1);
    rst = 1'b1;
    #1;
    chk("rst_req_valid", mem_req_valid_o, 0);
    chk("rst_req_ticket", mem_req_ticket_o, 0);
    chk("rst_idle", idle_o, 1);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    ready = 1'b1;
    v = 4'b1001;
    push_req(0);
    step(4'b0001, "rst_ptr_grant");
    v = '0;
    step('0, "post_rst_none");

    // Back-pressure on a ch2 store
    st[2] = 1'b1; a[2] = 32'h100; d[2] = 32'h0000_ABCD;
    v = 4'b0100;
    push_req(2);
    step(4'b0100, "bp_store_grant");
    v = 4'b1010;
    ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step('0, "bp_grant");
      chk("bp_valid", mem_req_valid_o, 1);
      chk("bp_store", mem_req_store_o, 1);
      chk("bp_addr", mem_req_addr_o, 32'h100);
      chk("bp_ticket", mem_req_ticket_o, 6'h26);
    end
    ready = 1'b1;
    st[2] = 1'b0;
    push_req(3);
    step(4'b1000, "bp_release_grant");
    v = '0;
    step('0, "bp_after");

    // Credit limit on ch1
    t[1] = 4'h9;
    v = 4'b0010;
    push_req(1);
    step(4'b0010, "cr_load1");
    push_req(1);
    step(4'b0010, "cr_load2");
    step('0, "cr_blocked");
    send_rsp(1, 4'h9, 32'h5555_0001);
    push_rsp(1'b0, 4'b0010, 4'h9, 32'h5555_0001);
    step('0, "cr_blocked_resp_cycle");
    rv = 1'b0;
    push_req(1);
    step(4'b0010, "cr_load3");
    v = '0;
    step('0, "cr_done");

    // Load grant and response on ch0 in one cycle leaves the credit count alone
    v = 4'b0001;
    send_rsp(0, 4'h3, 32'h0000_00C0);
    push_rsp(1'b0, 4'b0001, 4'h3, 32'h0000_00C0);
    push_req(0);
    step(4'b0001, "sim_grant");
    rv = 1'b0;
    push_req(0);
    step(4'b0001, "sim_grant2");
    step('0, "sim_cnt_max");
    st[0] = 1'b1;
    push_req(0);
    step(4'b0001, "sim_store_at_max");
    v = '0;
    st[0] = 1'b0;
    step('0, "sim_done");

    // Back-to-back ch1 responses drain its credits, then an unroutable one
    send_rsp(1, 4'hA, 32'h0000_00A1);
    push_rsp(1'b0, 4'b0010, 4'hA, 32'h0000_00A1);
    @(posedge clk);
    #1;
    send_rsp(1, 4'hB, 32'h0000_00A2);
    push_rsp(1'b0, 4'b0010, 4'hB, 32'h0000_00A2);
    @(posedge clk);
    #1;
    send_rsp(1, 4'hC, 32'h0000_00EE);
    push_rsp(1'b1, 4'b0000, 4'h0, 32'h0);
    @(posedge clk);
    #1;
    rv = 1'b0;
    v = 4'b0010;
    push_req(1);
    step(4'b0010, "err_cnt_kept");
    v = '0;
    step('0, "err_after");
    chk("busy_before_drain", idle_o, 0);

    // Drain remaining credits: ch0 x2, ch3 x1, ch1 x1
    send_rsp(0, 4'h1, 32'h0000_0B01);
    push_rsp(1'b0, 4'b0001, 4'h1, 32'h0000_0B01);
    @(posedge clk);
    #1;
    send_rsp(0, 4'h2, 32'h0000_0B02);
    push_rsp(1'b0, 4'b0001, 4'h2, 32'h0000_0B02);
    @(posedge clk);
    #1;
    send_rsp(3, 4'h7, 32'h0000_0B03);
    push_rsp(1'b0, 4'b1000, 4'h7, 32'h0000_0B03);
    @(posedge clk);
    #1;
    send_rsp(1, 4'h9, 32'h0000_0B04);
    push_rsp(1'b0, 4'b0010, 4'h9, 32'h0000_0B04);
    @(posedge clk);
    #1;
    rv = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("end_idle", idle_o, 1);
    chk("end_req_q_empty", req_q.size(), 0);
    chk("end_rsp_q_empty", rsp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vmu_mem_arbiter.md
# vmu_mem_arbiter

Parametrised memory-request arbiter and response router for the vector memory unit. It connects NUM_CH load/store engines to one cache port. It grants requests round-robin and registers the winning request in an output stage that holds under back-pressure. Each channel's outstanding loads are tracked against a credit limit, and load responses are routed back to their channel by a channel ID embedded in the ticket. It replaces the fixed two-engine, load-first mux of the previous VMU generation.

## Interface
- NUM_CH, 4, number of requesting engines (>=2); CH_W = $clog2(NUM_CH)
- ADDR_WIDTH, 32, request address width
- REQ_DATA_WIDTH, 256, request/response data width
- TICKET_WIDTH, 4, engine-local ticket width
- MAX_OUTST, 8, maximum outstanding loads per channel (>=1); counter width $clog2(MAX_OUTST+1)

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-high
- ch_req_valid_i  in  NUM_CH  per-channel request valid
- ch_req_store_i  in  NUM_CH  1 = store, 0 = load
- ch_req_addr_i  in  NUM_CH*ADDR_WIDTH  packed addresses, channel 0 in LSBs
- ch_req_data_i  in  NUM_CH*REQ_DATA_WIDTH  packed store data
- ch_req_ticket_i  in  NUM_CH*TICKET_WIDTH  packed engine tickets
- ch_grant_o  out  NUM_CH  one-hot grant, combinational; channel drops or advances its request after the grant cycle
- mem_req_valid_o  out  1  registered request valid
- mem_req_store_o  out  1  registered store flag
- mem_req_addr_o  out  ADDR_WIDTH  registered address
- mem_req_data_o  out  REQ_DATA_WIDTH  registered data
- mem_req_ticket_o  out  CH_W+TICKET_WIDTH  {channel id, engine ticket}
- cache_ready_i  in  1  cache accepts the request when valid and ready are both high
- mem_resp_valid_i  in  1  load response valid
- mem_resp_ticket_i  in  CH_W+TICKET_WIDTH  echoed ticket
- mem_resp_data_i  in  REQ_DATA_WIDTH  response data
- ch_resp_valid_o  out  NUM_CH  one-hot registered response valid
- ch_resp_ticket_o  out  TICKET_WIDTH  engine ticket, shared by all channels
- ch_resp_data_o  out  REQ_DATA_WIDTH  response data, shared by all channels
- resp_err_o  out  1  one-cycle pulse for an unroutable response
- idle_o  out  1  no pending request and no outstanding load

## Operation
- Reset values: all registered outputs are 0, the round-robin pointer is 0, and all credit counters are 0.
- Output stage is free when mem_req_valid_o==0, or when mem_req_valid_o & cache_ready_i (drain and refill in the same cycle).
- Eligibility: a channel is eligible when ch_req_valid_i[k] is high and either it is a store, or its credit counter is below MAX_OUTST.
- Grant rule: when the output stage is free, grant the first eligible channel scanning from rr_ptr upward, wrapping modulo NUM_CH.
  - If no channel is eligible, or the stage is not free, ch_grant_o is 0.
- On a grant to channel k:
  - Load the output register with the channel's store flag, address, data and ticket {k, ch_req_ticket_i[k]}.
  - Set rr_ptr to (k+1) mod NUM_CH.
  - If the request is a load, increment cnt[k].
- If the stage drains with no new grant, mem_req_valid_o goes to 0.
- Response handling: channel c = mem_resp_ticket_i[CH_W+TICKET_WIDTH-1:TICKET_WIDTH].
  - If c < NUM_CH and cnt[c] > 0: next cycle, ch_resp_valid_o[c]=1, ticket and data are driven, and cnt[c] decrements.
  - Otherwise: drop the response, pulse resp_err_o next cycle, and leave the counters unchanged.
- A load grant and a response for the same channel in the same cycle leave the counter unchanged.
- idle_o = ~mem_req_valid_o & (all cnt == 0), combinational from registers.
- Stores consume no credit and receive no response.
- Reset mid-operation drops the pending request and all credits; engines re-issue after reset.

## Timing
- Request latency: a grant in cycle t puts mem_req_valid_o high at t+1.
- Throughput: one request per cycle while cache_ready_i stays high.
- Back-pressure: while mem_req_valid_o & ~cache_ready_i, all mem_req_* outputs are stable and no grant is issued.
- Response latency: a response in cycle t appears on ch_resp_* at t+1.
- Back-to-back responses: one per cycle, no stall; there is no ready signal back to the cache.
- Credit freed by a response at t is visible to eligibility at t+1.

## Test plan
- Reset: assert rst mid-traffic -> all outputs 0, idle_o=1, rr_ptr=0, and a subsequent ch0 load is granted normally.
- Round-robin fairness: all 4 channels hold load valid with cache_ready_i=1 -> grants are 0,1,2,3,0 on consecutive cycles, and mem_req_ticket_o[5:4] follows the same sequence.
- Back-pressure: cache_ready_i=0 for 5 cycles after the ch2 store (addr 0x100) is registered -> mem_req_* are stable and ch_grant_o=0; on release, the next eligible channel is granted in the same cycle.
- Credit limit (MAX_OUTST=2): ch1 issues 3 loads with no responses -> the 3rd is not granted; a response with ticket {1,x} -> ch_resp_valid_o=0010 next cycle, and the 3rd load is granted the cycle after.
- Simultaneous events: ch0 load granted in the same cycle as a ch0 response -> cnt[0] unchanged; stores with cnt at the maximum are still granted.
- Error: a response with channel id 1 while cnt[1]=0 -> resp_err_o pulses for 1 cycle, ch_resp_valid_o=0, and counters are unchanged.
